// File: rtl/inst_rom_loader_if.sv
// ----------------------------------------------------------------------------
// inst_rom_loader_if
// Bundles the two buses of the writable instruction store:
//   - load stream : byte_i, byte_valid_i, byte_last_i (to loader), byte_ready_o
//   - fetch port  : rom_ce_i, rom_addr_i (to loader), rom_data_o
// Signal suffixes are from the loader's point of view.
// Modports:
//   slave  - the loader (inst_rom_loader)
//   master - the stream source / CPU side driving loads and fetches
// ----------------------------------------------------------------------------
interface inst_rom_loader_if;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_last_i;
   logic        byte_ready_o;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;

   modport slave (
      input  byte_i, byte_valid_i, byte_last_i, rom_ce_i, rom_addr_i,
      output byte_ready_o, rom_data_o
   );

   modport master (
      output byte_i, byte_valid_i, byte_last_i, rom_ce_i, rom_addr_i,
      input  byte_ready_o, rom_data_o
   );
endinterface

// File: rtl/inst_rom_loader.sv
// ----------------------------------------------------------------------------
// inst_rom_loader
// Writable instruction store replacing the fixed instruction ROM. A program
// image arrives as a byte stream, is packed big-endian into 32-bit words and
// written from word 0 upward while the CPU is held in reset. Once the last
// byte lands the CPU is released and fetches are served combinationally.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous, active-low reset
//   bus        - load stream + fetch port (inst_rom_loader_if.slave)
//   reload_i   - one-cycle request (RUN only) to discard the image and reload
//   cpu_rst_o  - active-high CPU reset, high while not running
//   loaded_o   - image loaded, CPU running
//   overflow_o - sticky: image was larger than the memory
//   words_o    - words written by the last load, saturating at 2**DEPTH_LOG2
// ----------------------------------------------------------------------------
module inst_rom_loader #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   inst_rom_loader_if.slave      bus,
   input  logic                  reload_i,
   output logic                  cpu_rst_o,
   output logic                  loaded_o,
   output logic                  overflow_o,
   output logic [DEPTH_LOG2:0]   words_o
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e                state_q,  state_d;
   logic [1:0]            cnt_q,    cnt_d;
   logic [31:0]           buf_q,    buf_d;
   logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
   logic                  ovf_q,    ovf_d;

   logic [31:0]           mem [DEPTH];
   logic [31:0]           merged;
   logic                  accept;
   logic                  mem_we;

   // Bits of the fetch address that play no part in the lookup (byte offset
   // and everything above the memory range, which aliases).
   logic                  unused_addr;
   assign unused_addr = ^{bus.rom_addr_i[31:DEPTH_LOG2+2], bus.rom_addr_i[1:0]};

   assign accept = (state_q == LOAD) && bus.byte_valid_i;

   // Word buffer with the incoming byte dropped into its big-endian slot.
   // Slots below the current position are still zero because the buffer is
   // cleared on every word write, so a partial word pads with 0x00.
   always_comb begin
      merged = buf_q;
      unique case (cnt_q)
         2'd0:    merged[31:24] = bus.byte_i;
         2'd1:    merged[23:16] = bus.byte_i;
         2'd2:    merged[15:8]  = bus.byte_i;
         default: merged[7:0]   = bus.byte_i;
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the branches below leaves it unassigned and infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q;
      ovf_d    = ovf_q;
      mem_we   = 1'b0;

      unique case (state_q)
         LOAD: begin
            if (accept) begin
               if (cnt_q == 2'd3 || bus.byte_last_i) begin
                  // Word complete (or image ends): write unless the memory is
                  // already full, in which case the word is dropped and the
                  // pointer stays saturated.
                  if (wr_ptr_q == PTR_FULL) begin
                     ovf_d = 1'b1;
                  end else begin
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                  end
                  buf_d = '0;
                  cnt_d = '0;
               end else begin
                  buf_d = merged;
                  cnt_d = cnt_q + 2'd1;
               end
               if (bus.byte_last_i) begin
                  state_d = RUN;
               end
            end
         end
         default: begin
            if (reload_i) begin
               state_d  = LOAD;
               ovf_d    = 1'b0;
               wr_ptr_d = '0;
               cnt_d    = '0;
               buf_d    = '0;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= LOAD;
         cnt_q    <= '0;
         buf_q    <= '0;
         wr_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         buf_q    <= buf_d;
         wr_ptr_q <= wr_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the memory array has no reset; contents must survive both reset
   // and reload, and a reset would stop it mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= merged;
      end
   end

   // Control outputs decode directly from the state register.
   assign bus.byte_ready_o = (state_q == LOAD);
   assign cpu_rst_o        = (state_q == LOAD);
   assign loaded_o         = (state_q == RUN);
   assign overflow_o       = ovf_q;
   assign words_o          = wr_ptr_q;

   // Zero-latency fetch, valid in any state.
   assign bus.rom_data_o = bus.rom_ce_i ? mem[bus.rom_addr_i[DEPTH_LOG2+1:2]] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// ----------------------------------------------------------------------------
// tb_inst_rom_loader
// Directed bench for inst_rom_loader. Two instances share clock and reset:
// dut_b with the default 1024-word memory and dut_s with a 4-word memory for
// the overflow / aliasing cases. Inputs change on the falling edge, outputs
// are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_inst_rom_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        reload_b, reload_s;
   logic        cpu_rst_b, loaded_b, ovf_b;
   logic        cpu_rst_s, loaded_s, ovf_s;
   logic [10:0] words_b;
   logic [2:0]  words_s;

   inst_rom_loader_if big_if ();
   inst_rom_loader_if small_if ();

   inst_rom_loader #(.DEPTH_LOG2(10)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .bus        (big_if.slave),
      .reload_i   (reload_b),
      .cpu_rst_o  (cpu_rst_b),
      .loaded_o   (loaded_b),
      .overflow_o (ovf_b),
      .words_o    (words_b)
   );

   inst_rom_loader #(.DEPTH_LOG2(2)) dut_s (
      .clk        (clk),
      .rst        (rst),
      .bus        (small_if.slave),
      .reload_i   (reload_s),
      .cpu_rst_o  (cpu_rst_s),
      .loaded_o   (loaded_s),
      .overflow_o (ovf_s),
      .words_o    (words_s)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_b(input logic [7:0] b, input logic last);
      @(negedge clk);
      big_if.byte_i       = b;
      big_if.byte_valid_i = 1'b1;
      big_if.byte_last_i  = last;
      @(posedge clk);
      #1;
      big_if.byte_valid_i = 1'b0;
      big_if.byte_last_i  = 1'b0;
   endtask

   task automatic send_s(input logic [7:0] b, input logic last);
      @(negedge clk);
      small_if.byte_i       = b;
      small_if.byte_valid_i = 1'b1;
      small_if.byte_last_i  = last;
      @(posedge clk);
      #1;
      small_if.byte_valid_i = 1'b0;
      small_if.byte_last_i  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fetch_b(input string tag, input logic [31:0] addr, input logic ce,
                          input logic [31:0] exp);
      big_if.rom_addr_i = addr;
      big_if.rom_ce_i   = ce;
      #1;
      check(tag, big_if.rom_data_o, exp);
   endtask

   task automatic fetch_s(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      small_if.rom_addr_i = addr;
      small_if.rom_ce_i   = 1'b1;
      #1;
      check(tag, small_if.rom_data_o, exp);
   endtask

   task automatic pulse_reload_b;
      @(negedge clk);
      reload_b = 1'b1;
      @(posedge clk);
      #1;
      reload_b = 1'b0;
   endtask

   initial begin
      rst                   = 1'b0;
      reload_b              = 1'b0;
      reload_s              = 1'b0;
      big_if.byte_i         = '0;
      big_if.byte_valid_i   = 1'b0;
      big_if.byte_last_i    = 1'b0;
      big_if.rom_ce_i       = 1'b0;
      big_if.rom_addr_i     = '0;
      small_if.byte_i       = '0;
      small_if.byte_valid_i = 1'b0;
      small_if.byte_last_i  = 1'b0;
      small_if.rom_ce_i     = 1'b0;
      small_if.rom_addr_i   = '0;

      // Reset values
      #12;
      check("rst_cpu_rst", 32'(cpu_rst_b), 32'd1);
      check("rst_ready",   32'(big_if.byte_ready_o), 32'd1);
      check("rst_loaded",  32'(loaded_b), 32'd0);
      check("rst_ovf",     32'(ovf_b), 32'd0);
      check("rst_words",   32'(words_b), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Basic 8-byte image
      send_b(8'h34, 1'b0); send_b(8'h01, 1'b0); send_b(8'h00, 1'b0); send_b(8'h10, 1'b0);
      send_b(8'h3C, 1'b0); send_b(8'h02, 1'b0); send_b(8'hAB, 1'b0);
      @(negedge clk);
      big_if.byte_i       = 8'hCD;
      big_if.byte_valid_i = 1'b1;
      big_if.byte_last_i  = 1'b1;
      check("pre_last_cpu_rst", 32'(cpu_rst_b), 32'd1);
      @(posedge clk);
      #1;
      big_if.byte_valid_i = 1'b0;
      big_if.byte_last_i  = 1'b0;
      check("last_cpu_rst",  32'(cpu_rst_b), 32'd0);
      check("last_loaded",   32'(loaded_b), 32'd1);
      check("last_ready",    32'(big_if.byte_ready_o), 32'd0);
      check("last_words",    32'(words_b), 32'd2);
      fetch_b("fetch_w0",     32'h0000_0000, 1'b1, 32'h3401_0010);
      fetch_b("fetch_w1",     32'h0000_0004, 1'b1, 32'h3C02_ABCD);
      fetch_b("fetch_ce0",    32'h0000_0004, 1'b0, 32'h0000_0000);
      fetch_b("fetch_lowbit", 32'h0000_0007, 1'b1, 32'h3C02_ABCD);
      fetch_b("fetch_alias",  32'h0000_1004, 1'b1, 32'h3C02_ABCD);

      // Stream bytes in RUN (with last) are ignored
      @(negedge clk);
      big_if.byte_i       = 8'hFF;
      big_if.byte_valid_i = 1'b1;
      big_if.byte_last_i  = 1'b1;
      idle(3);
      big_if.byte_valid_i = 1'b0;
      big_if.byte_last_i  = 1'b0;
      check("run_ign_words",  32'(words_b), 32'd2);
      check("run_ign_loaded", 32'(loaded_b), 32'd1);
      fetch_b("run_ign_w0", 32'h0, 1'b1, 32'h3401_0010);
      fetch_b("run_ign_w1", 32'h4, 1'b1, 32'h3C02_ABCD);

      // Reload, then 6 bytes with gaps
      pulse_reload_b();
      check("reload_cpu_rst", 32'(cpu_rst_b), 32'd1);
      check("reload_loaded",  32'(loaded_b), 32'd0);
      check("reload_ovf",     32'(ovf_b), 32'd0);
      check("reload_words",   32'(words_b), 32'd0);
      check("reload_ready",   32'(big_if.byte_ready_o), 32'd1);
      send_b(8'h11, 1'b0); send_b(8'h12, 1'b0);
      idle(1);
      send_b(8'h13, 1'b0); send_b(8'h14, 1'b0);
      check("gap_words_a", 32'(words_b), 32'd1);
      pulse_reload_b();          // ignored in LOAD
      idle(2);
      check("gap_words_b",      32'(words_b), 32'd1);
      check("gap_ready",        32'(big_if.byte_ready_o), 32'd1);
      check("load_reload_ign",  32'(cpu_rst_b), 32'd1);
      send_b(8'h15, 1'b0);
      idle(2);
      check("gap_words_c", 32'(words_b), 32'd1);
      fetch_b("gap_w1_old", 32'h4, 1'b1, 32'h3C02_ABCD);
      send_b(8'h16, 1'b1);
      check("gap_words_end", 32'(words_b), 32'd2);
      check("gap_loaded",    32'(loaded_b), 32'd1);
      fetch_b("gap_w0", 32'h0, 1'b1, 32'h1112_1314);
      fetch_b("gap_w1", 32'h4, 1'b1, 32'h1516_0000);

      // Reload with a one-word image; word 1 retained
      pulse_reload_b();
      send_b(8'hDE, 1'b0); send_b(8'hAD, 1'b0); send_b(8'hBE, 1'b0); send_b(8'hEF, 1'b1);
      check("deadbeef_words", 32'(words_b), 32'd1);
      fetch_b("deadbeef_w0", 32'h0, 1'b1, 32'hDEAD_BEEF);
      fetch_b("deadbeef_w1", 32'h4, 1'b1, 32'h1516_0000);

      // Asynchronous reset mid-load
      pulse_reload_b();
      send_b(8'hAA, 1'b0); send_b(8'hBB, 1'b0); send_b(8'hCC, 1'b0); send_b(8'hDD, 1'b0);
      send_b(8'hEE, 1'b0);
      check("pre_arst_words", 32'(words_b), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("arst_words",   32'(words_b), 32'd0);
      check("arst_cpu_rst", 32'(cpu_rst_b), 32'd1);
      check("arst_ready",   32'(big_if.byte_ready_o), 32'd1);
      check("arst_loaded",  32'(loaded_b), 32'd0);
      check("arst_ovf",     32'(ovf_b), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      send_b(8'h00, 1'b0); send_b(8'h00, 1'b0); send_b(8'h00, 1'b0); send_b(8'h00, 1'b1);
      check("post_arst_words", 32'(words_b), 32'd1);
      fetch_b("post_arst_w0", 32'h0, 1'b1, 32'h0000_0000);
      fetch_b("post_arst_w1", 32'h4, 1'b1, 32'h1516_0000);

      // Small memory: 20 bytes into 4 words
      for (int i = 1; i <= 20; i++) begin
         send_s(8'(i), i == 20);
         if (i == 16) begin
            check("s_full_words", 32'(words_s), 32'd4);
            check("s_full_ovf",   32'(ovf_s), 32'd0);
         end
      end
      check("s_ovf",    32'(ovf_s), 32'd1);
      check("s_words",  32'(words_s), 32'd4);
      check("s_loaded", 32'(loaded_s), 32'd1);
      check("s_cpu_rst", 32'(cpu_rst_s), 32'd0);
      fetch_s("s_w0",    32'h00, 32'h0102_0304);
      fetch_s("s_w3",    32'h0C, 32'h0D0E_0F10);
      fetch_s("s_alias", 32'h10, 32'h0102_0304);
      @(negedge clk);
      reload_s = 1'b1;
      @(posedge clk);
      #1;
      reload_s = 1'b0;
      check("s_reload_ovf",   32'(ovf_s), 32'd0);
      check("s_reload_words", 32'(words_s), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Writable instruction store that replaces the fixed instruction ROM in the minimal SOPC. It receives a program image as a byte stream, packs it big-endian into 32-bit words, and writes them from word 0 upward. It holds the CPU in reset during loading, then serves instruction fetches on the same port shape the CPU core already drives (address, chip enable, instruction data).

## Interface
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words, 4 KiB)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- byte_i  in  8  load stream data byte
- byte_valid_i  in  1  byte_i valid this cycle
- byte_last_i  in  1  qualifies the final byte of the image; sampled with byte_valid_i
- byte_ready_o  out  1  loader can accept a byte this cycle
- reload_i  in  1  single-cycle request to discard the running image and reload
- cpu_rst_o  out  1  active-high reset to the CPU core; high while not running
- rom_ce_i  in  1  fetch chip enable from the CPU
- rom_addr_i  in  32  fetch byte address from the CPU
- rom_data_o  out  32  fetched instruction
- loaded_o  out  1  image loaded, CPU running
- overflow_o  out  1  sticky: image exceeded memory depth
- words_o  out  DEPTH_LOG2+1  number of words written by the last load

## Operation
- States: LOAD, RUN. Reset enters LOAD.
- LOAD: byte_ready_o=1. A byte is accepted when byte_valid_i && byte_ready_o.
  - Accepted bytes fill the word buffer big-endian: byte 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0]. A 2-bit byte counter tracks the position.
  - On acceptance of byte 3, write the word to mem[wr_ptr], increment wr_ptr, clear the counter.
  - On acceptance of a byte with byte_last_i=1:
    - Write the word even if partial; unfilled low bytes are 0x00.
    - If the counter was 0 before this byte, it is still a partial word and is written.
    - Transition to RUN.
  - Overflow: a write with wr_ptr == 2^DEPTH_LOG2 is discarded, and overflow_o sets. wr_ptr saturates and does not wrap. Loading continues until the last byte.
- RUN: byte_ready_o=0; stream bytes are ignored. cpu_rst_o=0, loaded_o=1.
- reload_i is honoured only in RUN. It moves to LOAD, sets cpu_rst_o=1, and clears loaded_o, overflow_o, wr_ptr, the byte counter and words_o. Memory contents are retained until overwritten. reload_i in LOAD is ignored.
- Fetch (combinational):
  - rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]] when rom_ce_i=1, else 0.
  - Higher address bits are ignored (aliasing). rom_addr_i[1:0] is ignored.
  - Fetch is valid in any state; in LOAD the CPU is held in reset.
- words_o = wr_ptr, saturating at 2^DEPTH_LOG2.

## Timing
- Reset values while rst=0:
  - state=LOAD, cpu_rst_o=1, byte_ready_o=1, loaded_o=0, overflow_o=0, words_o=0.
  - wr_ptr=0, byte counter=0, word buffer=0. Memory is not cleared.
- Throughput is one byte per cycle; there are no bubbles between words.
- The memory write happens on the same edge that accepts the completing byte.
- On the edge that accepts the last byte: the final word is written, the state becomes RUN, and cpu_rst_o falls. The CPU's first fetch, in the following cycle, sees the written data.
- reload_i sampled high in RUN: on that edge cpu_rst_o rises and byte_ready_o rises. A byte can be accepted in the next cycle.
- Async assertion of rst mid-load aborts the load immediately. Words already written stay in memory. After release, loading restarts at word 0.
- Read latency is 0 cycles (combinational), matching the original ROM behaviour.

## Test plan
- Reset, then stream 8 bytes 0x34,0x01,0x00,0x10, 0x3C,0x02,0xAB,0xCD with last on the 8th → mem[0]=0x34010010 and mem[1]=0x3C02ABCD; cpu_rst_o falls on the edge accepting the 8th byte; words_o=2; fetch at addr 0x4 with ce=1 returns 0x3C02ABCD; with ce=0 returns 0.
- Stream 6 bytes 0x11..0x16 with last on 0x16, including byte_valid_i gaps of 1–3 cycles → mem[1]=0x15160000, words_o=2, no extra writes during gaps.
- DEPTH_LOG2=2: stream 20 bytes → words 0–3 written, the 5th word discarded, overflow_o=1, words_o=4; fetch at 0x10 aliases to word 0.
- In RUN, pulse reload_i → cpu_rst_o=1, loaded_o=0, overflow_o=0, words_o=0. Reload 4 bytes 0xDEADBEEF with last → mem[0]=0xDEADBEEF, mem[1] still holds its old value.
- Drive rst low after 5 bytes of a load → all outputs at reset values asynchronously, before the next clk edge. Reload 4 bytes 0x00000000 → mem[0]=0, while mem[1] keeps the word written before the reset.
- Hold byte_valid_i high in RUN with arbitrary data → no memory change and words_o unchanged.
